// File: rtl/uart_mmio_responder_pkg.sv
// uart_mmio_responder_pkg: UART register word addresses and USR bit positions.
package uart_mmio_responder_pkg;
  localparam logic [31:0] UBRR_addr = 32'h0000_0400;
  localparam logic [31:0] UCSZ_addr = 32'h0000_0401;
  localparam logic [31:0] UCR_addr  = 32'h0000_0402;
  localparam logic [31:0] UDRT_addr = 32'h0000_0403;
  localparam logic [31:0] USR_addr  = 32'h0000_0404;
  localparam logic [31:0] UDRR_addr = 32'h0000_0405;
  localparam int USR_TX_FULL = 0;
  localparam int USR_RX_NE   = 1;
  localparam int USR_OVR     = 2;
  localparam int USR_TX_IDLE = 3;
endpackage

// File: rtl/uart_mmio_responder_sync_fifo.sv
// sync_fifo: pointer-based FIFO; a push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0] r_wp, r_rp;
  logic w_push, w_pop;
  assign full   = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign empty  = r_wp == r_rp;
  assign head   = r_mem[r_rp[AW-1:0]];
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + ONE;
      if (w_pop) r_rp <= r_rp + ONE;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/uart_mmio_responder.sv
// uart_mmio_responder: CPU-side UART registers with TX/RX FIFOs and TX start sequencer.
// Optional macro UART_RX_IRQ_EN adds a registered irq output gated by ucr[1].
module uart_mmio_responder
  import uart_mmio_responder_pkg::*;
#(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        ready,
  output logic [11:0] ubrr,
  output logic [3:0]  ucsz,
  output logic [1:0]  ucr,
  output logic [7:0]  udrt,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic        rx_done,
`ifdef UART_RX_IRQ_EN
  input  logic [7:0]  rx_data,
  output logic        irq
`else
  input  logic [7:0]  rx_data
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT_BUSY, S_WAIT_DONE} tx_state_t;
  tx_state_t r_state, w_state_nx;
  logic [11:0] r_ubrr;
  logic [3:0]  r_ucsz;
  logic [1:0]  r_ucr;
  logic [7:0]  r_udrt;
  logic        r_tx_start, r_ovr;
  logic        w_st, w_ld, w_udrt_wr, w_usr_wr;
  logic        w_tx_full, w_tx_empty, w_tx_pop, w_tx_idle;
  logic        w_rx_full, w_rx_empty, w_rx_pop;
  logic [7:0]  w_tx_head, w_rx_head;
  logic [3:0]  w_usr;
  logic        w_unused;
  assign hit = addr == UBRR_addr || addr == UCSZ_addr || addr == UCR_addr ||
               addr == UDRT_addr || addr == USR_addr  || addr == UDRR_addr;
  assign w_st      = we & hit;
  assign w_ld      = re & ~we & hit;
  assign w_udrt_wr = w_st & (addr == UDRT_addr);
  assign w_usr_wr  = w_st & (addr == USR_addr);
  assign w_rx_pop  = w_ld & (addr == UDRR_addr) & ~w_rx_empty;
  assign w_tx_idle = w_tx_empty & (r_state == S_IDLE);
  // A blocked UDRT store proceeds in the same cycle the sequencer frees a slot.
  assign ready     = ~(w_udrt_wr & w_tx_full & ~w_tx_pop);
  assign w_unused  = &wdata[31:12];
  always_comb begin
    w_usr = '0;
    w_usr[USR_TX_FULL] = w_tx_full;
    w_usr[USR_RX_NE]   = ~w_rx_empty;
    w_usr[USR_OVR]     = r_ovr;
    w_usr[USR_TX_IDLE] = w_tx_idle;
    rdata = !w_ld                ? 32'd0 :
            addr == UBRR_addr    ? {20'd0, r_ubrr} :
            addr == UCSZ_addr    ? {28'd0, r_ucsz} :
            addr == UCR_addr     ? {30'd0, r_ucr} :
            addr == USR_addr     ? {28'd0, w_usr} :
            addr == UDRR_addr && !w_rx_empty ? {24'd0, w_rx_head} : 32'd0;
  end
  always_comb begin
    w_tx_pop   = (r_state == S_IDLE) & ~w_tx_empty;
    w_state_nx = r_state == S_IDLE      ? (w_tx_empty ? S_IDLE : S_WAIT_BUSY) :
                 r_state == S_WAIT_BUSY ? (tx_busy ? S_WAIT_DONE : S_WAIT_BUSY) :
                                          (tx_busy ? S_WAIT_DONE : S_IDLE);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_ubrr     <= '0;
      r_ucsz     <= '0;
      r_ucr      <= '0;
      r_udrt     <= '0;
      r_tx_start <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_tx_start <= w_tx_pop;
      if (w_tx_pop) r_udrt <= w_tx_head;
      if (w_st && addr == UBRR_addr) r_ubrr <= wdata[11:0];
      if (w_st && addr == UCSZ_addr) r_ucsz <= wdata[3:0];
      if (w_st && addr == UCR_addr) r_ucr <= wdata[1:0];
      r_ovr <= (rx_done & w_rx_full & ~w_rx_pop) | (r_ovr & ~(w_usr_wr & wdata[USR_OVR]));
    end
  end
`ifdef UART_RX_IRQ_EN
  logic r_irq;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_irq <= 1'b0;
    else r_irq <= r_ucr[1] & (~w_rx_empty | r_ovr);
  end
  assign irq = r_irq;
`endif
  assign ubrr     = r_ubrr;
  assign ucsz     = r_ucsz;
  assign ucr      = r_ucr;
  assign udrt     = r_udrt;
  assign tx_start = r_tx_start;
  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(w_udrt_wr), .din(wdata[7:0]), .pop(w_tx_pop),
    .full(w_tx_full), .empty(w_tx_empty), .head(w_tx_head)
  );
  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_done), .din(rx_data), .pop(w_rx_pop),
    .full(w_rx_full), .empty(w_rx_empty), .head(w_rx_head)
  );
endmodule
